// File: rtl/gray_step_sequencer.sv
// gray_step_sequencer
//   Produces the clk_en strobes for a gray_Nbits counter at a programmable rate.
//   It can free-run, run a counted number of steps, or issue a single step.
//   It also watches the counter's output for wrap-around and, when the checker
//   is built in, for illegal Gray transitions.
//
// Build option:
//   GRAY_CHECK_EN  defined   -> gray_err is a sticky illegal-transition flag
//                  undefined -> gray_err is tied to 0 and no checker is built
//
// Ports:
//   clk, rst        system clock (rising edge), synchronous active-high reset
//   start           begin a run; div_val/num_steps are captured here
//   stop            abort a run or a step
//   step            issue exactly one enable from IDLE
//   div_val         enable period minus 1
//   num_steps       enables per run, 0 = free-run
//   gray_in         gray_out of the driven counter
//   clk_en          registered one-cycle enable strobe to the counter
//   busy            high while in RUN or STEP
//   done            one-cycle pulse after the final enable of a counted run
//   steps_done      enables issued since the last start/step
//   wrap            one-cycle pulse after gray_in returns to 0
//   gray_err        sticky illegal-transition flag
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start/step, no enables issued
// S_RUN  | prescaler running, enable on every terminal count
// S_STEP | single enable in flight, back to idle next cycle
module gray_step_sequencer #(
  parameter int N     = 5,
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic [DIV_W-1:0] div_val,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [N-1:0]     gray_in,
  output logic             clk_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] steps_done,
  output logic             wrap,
  output logic             gray_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] presc, presc_nx, presc_dec;
  logic [DIV_W-1:0] div_cap, div_nx;
  logic [CNT_W-1:0] num_cap, num_nx;
  logic [CNT_W-1:0] steps_nx;
  logic             clk_en_nx;
  logic             done_nx;
  logic             last_step;
  logic [N-1:0]     prev_gray;

  // Down-counter reloads on terminal count; a zero next value means the
  // strobe is registered for the following cycle.
  assign presc_dec = (presc == '0) ? div_cap : (presc - DIV_W'(1));

  // The enable currently on clk_en is the last one of a counted run.
  assign last_step = (num_cap != '0) && ((steps_done + CNT_W'(1)) == num_cap);

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    presc_nx  = presc;
    div_nx    = div_cap;
    num_nx    = num_cap;
    steps_nx  = steps_done + CNT_W'(clk_en);
    clk_en_nx = 1'b0;
    done_nx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (start) begin
          state_nx  = S_RUN;
          div_nx    = div_val;
          num_nx    = num_steps;
          presc_nx  = div_val;
          steps_nx  = '0;
          clk_en_nx = (div_val == '0);
        end else if (step) begin
          state_nx  = S_STEP;
          steps_nx  = '0;
          clk_en_nx = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nx = S_IDLE;
        end else if (clk_en && last_step) begin
          // Leaving here also suppresses the strobe a zero divider would
          // otherwise register on this edge.
          state_nx = S_IDLE;
          done_nx  = 1'b1;
        end else begin
          presc_nx  = presc_dec;
          clk_en_nx = (presc_dec == '0);
        end
      end
      S_STEP: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      presc      <= '0;
      div_cap    <= '0;
      num_cap    <= '0;
      steps_done <= '0;
      clk_en     <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      presc      <= presc_nx;
      div_cap    <= div_nx;
      num_cap    <= num_nx;
      steps_done <= steps_nx;
      clk_en     <= clk_en_nx;
      done       <= done_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      wrap      <= 1'b0;
    end else begin
      prev_gray <= gray_in;
      wrap      <= (gray_in == '0) && (prev_gray != '0);
    end
  end

`ifdef GRAY_CHECK_EN
  logic         start_accept;
  logic [N-1:0] gray_diff;
  logic         gray_bad;

  assign start_accept = (state == S_IDLE) && !stop && start;
  assign gray_diff    = gray_in ^ prev_gray;
  // Non-zero difference that is not a power of two: more than one bit flipped.
  assign gray_bad     = (gray_diff != '0) && ((gray_diff & (gray_diff - N'(1))) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      gray_err <= 1'b0;
    end else if (start_accept) begin
      gray_err <= 1'b0;
    end else if (gray_bad) begin
      gray_err <= 1'b1;
    end
  end
`else
  assign gray_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_step_sequencer.sv
module tb_gray_step_sequencer;

  localparam int N     = 5;
  localparam int DIV_W = 8;
  localparam int CNT_W = 16;

`ifdef GRAY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             step;
  logic [DIV_W-1:0] div_val;
  logic [CNT_W-1:0] num_steps;
  logic [N-1:0]     gray_in;
  logic             clk_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] steps_done;
  logic             wrap;
  logic             gray_err;

  // Behavioural stand-in for the gray_Nbits counter driven by clk_en.
  logic [N-1:0] bin_cnt;
  logic [N-1:0] gray_model;
  logic [N-1:0] gray_force;
  logic         use_model;

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) bin_cnt <= '0;
    else if (clk_en) bin_cnt <= bin_cnt + 5'd1;
  end
  assign gray_model = bin_cnt ^ (bin_cnt >> 1);
  assign gray_in    = use_model ? gray_model : gray_force;

  gray_step_sequencer #(.N(N), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .step       (step),
    .div_val    (div_val),
    .num_steps  (num_steps),
    .gray_in    (gray_in),
    .clk_en     (clk_en),
    .busy       (busy),
    .done       (done),
    .steps_done (steps_done),
    .wrap       (wrap),
    .gray_err   (gray_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks_total++;
    if ({clk_en, busy, done, wrap, gray_err} !== 5'b0)
      $display("FAIL reset_flags: got %b expected 00000", {clk_en, busy, done, wrap, gray_err});
    else checks_passed++;
    checks_total++;
    if (steps_done !== 16'd0)
      $display("FAIL reset_steps: got %0d expected 0", steps_done);
    else checks_passed++;
    tick();
    checks_total++;
    if ({clk_en, busy} !== 2'b00)
      $display("FAIL reset_idle: got %b expected 00", {clk_en, busy});
    else checks_passed++;
  endtask

  // div 3, 4 steps: enables at cycles 4,8,12,16 after start, done at 17.
  task automatic test_counted_run();
    int exp_steps;
    div_val   = 8'd3;
    num_steps = 16'd4;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    div_val   = 8'd1;
    num_steps = 16'd9;
    for (int c = 1; c <= 18; c++) begin
      exp_steps = (c - 1) / 4;
      if (exp_steps > 4) exp_steps = 4;
      checks_total++;
      if (clk_en !== ((c % 4 == 0) && (c <= 16)))
        $display("FAIL counted_clk_en c=%0d: got %b expected %b", c, clk_en, (c % 4 == 0) && (c <= 16));
      else checks_passed++;
      checks_total++;
      if ({busy, done} !== {(c <= 16), (c == 17)})
        $display("FAIL counted_busy_done c=%0d: got %b expected %b", c, {busy, done}, {(c <= 16), (c == 17)});
      else checks_passed++;
      checks_total++;
      if (steps_done !== exp_steps[CNT_W-1:0])
        $display("FAIL counted_steps c=%0d: got %0d expected %0d", c, steps_done, exp_steps);
      else checks_passed++;
      tick();
    end
  endtask

  // div 0, free-run against the counter model: wraps every 32 enables.
  task automatic test_free_run();
    do_reset();
    div_val   = 8'd0;
    num_steps = 16'd0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      checks_total++;
      if ({clk_en, busy} !== 2'b11)
        $display("FAIL free_clk_en c=%0d: got %b expected 11", c, {clk_en, busy});
      else checks_passed++;
      checks_total++;
      if (wrap !== ((c == 34) || (c == 66)))
        $display("FAIL free_wrap c=%0d: got %b expected %b", c, wrap, (c == 34) || (c == 66));
      else checks_passed++;
      checks_total++;
      if (steps_done !== 16'(c - 1))
        $display("FAIL free_steps c=%0d: got %0d expected %0d", c, steps_done, c - 1);
      else checks_passed++;
      if (c == 70) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks_total++;
      if ({clk_en, busy, done, wrap} !== 4'b0000)
        $display("FAIL free_after_stop c=%0d: got %b expected 0000", c, {clk_en, busy, done, wrap});
      else checks_passed++;
      tick();
    end
    checks_total++;
    if (steps_done !== 16'd70)
      $display("FAIL free_stop_steps: got %0d expected 70", steps_done);
    else checks_passed++;
    checks_total++;
    if (gray_err !== 1'b0)
      $display("FAIL free_gray_err: got %b expected 0", gray_err);
    else checks_passed++;
  endtask

  task automatic test_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    checks_total++;
    if ({clk_en, busy, done} !== 3'b110)
      $display("FAIL step_pulse: got %b expected 110", {clk_en, busy, done});
    else checks_passed++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks_total++;
      if ({clk_en, busy, done} !== 3'b000)
        $display("FAIL step_after c=%0d: got %b expected 000", c, {clk_en, busy, done});
      else checks_passed++;
      checks_total++;
      if (steps_done !== 16'd1)
        $display("FAIL step_count c=%0d: got %0d expected 1", c, steps_done);
      else checks_passed++;
    end
    // step held through a run is ignored while busy.
    div_val   = 8'd1;
    num_steps = 16'd2;
    start     = 1'b1;
    step      = 1'b1;
    tick();
    start     = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      checks_total++;
      if ({clk_en, busy, done} !== {(c == 2) || (c == 4), (c <= 4), (c == 5)})
        $display("FAIL step_held c=%0d: got %b expected %b", c, {clk_en, busy, done},
                 {(c == 2) || (c == 4), (c <= 4), (c == 5)});
      else checks_passed++;
      if (c == 5) step = 1'b0;
      tick();
    end
    checks_total++;
    if (steps_done !== 16'd2)
      $display("FAIL step_held_steps: got %0d expected 2", steps_done);
    else checks_passed++;
  endtask

  task automatic test_start_stop_together();
    div_val   = 8'd0;
    num_steps = 16'd0;
    start     = 1'b1;
    stop      = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks_total++;
      if ({clk_en, busy} !== 2'b00)
        $display("FAIL start_stop c=%0d: got %b expected 00", c, {clk_en, busy});
      else checks_passed++;
    end
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_stop_on_final();
    div_val   = 8'd0;
    num_steps = 16'd3;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tick();
    tick();
    checks_total++;
    if ({clk_en, busy} !== 2'b11)
      $display("FAIL final_pre: got %b expected 11", {clk_en, busy});
    else checks_passed++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks_total++;
    if ({clk_en, busy, done} !== 3'b000)
      $display("FAIL final_stop: got %b expected 000", {clk_en, busy, done});
    else checks_passed++;
    checks_total++;
    if (steps_done !== 16'd3)
      $display("FAIL final_steps: got %0d expected 3", steps_done);
    else checks_passed++;
    tick();
    checks_total++;
    if (done !== 1'b0)
      $display("FAIL final_no_done: got %b expected 0", done);
    else checks_passed++;
  endtask

  task automatic test_reset_mid_run();
    div_val   = 8'd1;
    num_steps = 16'd0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    tick(); tick(); tick(); tick();
    checks_total++;
    if ({busy, steps_done} !== {1'b1, 16'd2})
      $display("FAIL midrst_pre: got %b/%0d expected 1/2", busy, steps_done);
    else checks_passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks_total++;
    if ({clk_en, busy, done, wrap, gray_err} !== 5'b0 || steps_done !== 16'd0)
      $display("FAIL midrst_outputs: got %b/%0d expected 00000/0",
               {clk_en, busy, done, wrap, gray_err}, steps_done);
    else checks_passed++;
    tick();
    checks_total++;
    if ({clk_en, busy} !== 2'b00)
      $display("FAIL midrst_idle: got %b expected 00", {clk_en, busy});
    else checks_passed++;
  endtask

  task automatic test_gray_check();
    use_model  = 1'b0;
    gray_force = 5'b00000;
    do_reset();
    gray_force = 5'b00001;
    tick();
    tick();
    checks_total++;
    if (gray_err !== 1'b0)
      $display("FAIL gray_legal: got %b expected 0", gray_err);
    else checks_passed++;
    gray_force = 5'b00111;
    tick();
    checks_total++;
    if (gray_err !== CHK)
      $display("FAIL gray_err_set: got %b expected %b", gray_err, CHK);
    else checks_passed++;
    tick(); tick();
    checks_total++;
    if (gray_err !== CHK)
      $display("FAIL gray_err_sticky: got %b expected %b", gray_err, CHK);
    else checks_passed++;
    div_val   = 8'd0;
    num_steps = 16'd1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    checks_total++;
    if ({gray_err, busy} !== 2'b01)
      $display("FAIL gray_err_clear: got %b expected 01", {gray_err, busy});
    else checks_passed++;
    tick();
    checks_total++;
    if ({done, busy} !== 2'b10)
      $display("FAIL gray_run_done: got %b expected 10", {done, busy});
    else checks_passed++;
    use_model = 1'b1;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    stop       = 1'b0;
    step       = 1'b0;
    div_val    = '0;
    num_steps  = '0;
    gray_force = '0;
    use_model  = 1'b1;
    test_reset();
    test_counted_run();
    test_free_run();
    test_step();
    test_start_stop_together();
    test_stop_on_final();
    test_reset_mid_run();
    test_gray_check();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
